// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Purpose  : Sequencer for a ROWS x COLS array of MAC PEs. Loads weights
//            (absolute or incremental) one PE at a time, then runs
//            matrix-vector ops: clear accumulators, feed skewed inputs,
//            capture one result word per row and hold it for the consumer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   start_load_i/load_mode_i start a weight load (0 absolute, 1 incremental)
//   wt_valid_i/wt_ready_o    weight word handshake, wt_data_i row-major
//   load_done_o              one-cycle pulse when the last weight is applied
//   in_valid_i/in_ready_o    input vector handshake, x[c] in in_data_i
//   res_valid_o/res_ready_i  result handshake, y[r] in res_data_o
//   busy_o                   controller not idle
//   arr_*_o / arr_outp_i     control and data to/from the PE array
//   op_count_o               completed-op counter
// Options
//   SYSTOLIC_CTRL_PERF_EN    when defined, op_count_o counts result
//                            handshakes (wrapping); otherwise tied to 0.
// ============================================================================
module systolic_ctrl #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DATAWIDTH = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_load_i,
  input  logic                          load_mode_i,
  input  logic                          wt_valid_i,
  output logic                          wt_ready_o,
  input  logic [DATAWIDTH-1:0]          wt_data_i,
  output logic                          load_done_o,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [COLS*DATAWIDTH-1:0]     in_data_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [ROWS*2*DATAWIDTH-1:0]   res_data_o,
  output logic                          busy_o,
  output logic                          arr_rst_vals_o,
  output logic                          arr_rst_overall_o,
  output logic [ROWS*COLS-1:0]          arr_train_en_o,
  output logic [DATAWIDTH-1:0]          arr_weight_update_o,
  output logic [COLS*DATAWIDTH-1:0]     arr_value_o,
  input  logic [ROWS*2*DATAWIDTH-1:0]   arr_outp_i,
  output logic [15:0]                   op_count_o
);

  localparam int NPE   = ROWS * COLS;
  localparam int IDX_W = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int K_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW    = DATAWIDTH;
  localparam int RES_W = ROWS * 2 * DATAWIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WCLR  = 3'd1,
    S_WLOAD = 3'd2,
    S_WDONE = 3'd3,
    S_CCLR  = 3'd4,
    S_FEED  = 3'd5,
    S_CAPT  = 3'd6,
    S_HOLD  = 3'd7
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [COLS*DW-1:0]    x_q, x_d;
  logic [RES_W-1:0]      res_data_q, res_data_d;
  logic                  res_valid_q, res_valid_d;
  logic                  wt_ready_q, wt_ready_d;
  logic                  in_ready_q, in_ready_d;
  logic                  load_done_q, load_done_d;
  logic                  busy_q, busy_d;
  logic                  rst_vals_q, rst_vals_d;
  logic                  rst_overall_q, rst_overall_d;
  logic [NPE-1:0]        train_q, train_d;
  logic [DW-1:0]         wt_upd_q, wt_upd_d;
  logic [COLS*DW-1:0]    value_q, value_d;

  // A load request in IDLE takes priority over an input vector, so ready is
  // withdrawn in that same cycle to keep the input handshake honest.
  assign in_ready_o = in_ready_q & ~start_load_i;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    k_d           = k_q;
    x_d           = x_q;
    res_data_d    = res_data_q;
    res_valid_d   = res_valid_q;
    wt_upd_d      = wt_upd_q;
    train_d       = '0;
    value_d       = '0;
    rst_vals_d    = 1'b0;
    rst_overall_d = 1'b0;
    load_done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_load_i) begin
          idx_d = '0;
          if (!load_mode_i) begin
            state_d       = S_WCLR;
            rst_overall_d = 1'b1;
          end else begin
            state_d = S_WLOAD;
          end
        end else if (in_valid_i && in_ready_o) begin
          x_d        = in_data_i;
          state_d    = S_CCLR;
          rst_vals_d = 1'b1;
        end
      end
      S_WCLR: state_d = S_WLOAD;
      S_WLOAD: begin
        if (wt_valid_i && wt_ready_q) begin
          train_d  = NPE'(1) << idx_q;
          wt_upd_d = wt_data_i;
          idx_d    = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NPE - 1)) begin
            state_d     = S_WDONE;
            load_done_d = 1'b1;
          end
        end
      end
      S_WDONE: state_d = S_IDLE;
      S_CCLR: begin
        // Column 0 is driven in the first FEED cycle.
        state_d             = S_FEED;
        k_d                 = '0;
        value_d[0 +: DW]    = x_q[0 +: DW];
      end
      S_FEED: begin
        // Outputs are registered, so the column presented next cycle is k+1.
        if (k_q == K_W'(COLS - 1)) begin
          state_d = S_CAPT;
        end else begin
          k_d = k_q + K_W'(1);
          for (int c = 1; c < COLS; c++) begin
            if (K_W'(c) == k_d) value_d[c*DW +: DW] = x_q[c*DW +: DW];
          end
        end
      end
      S_CAPT: begin
        res_data_d  = arr_outp_i;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (res_valid_q && res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wt_ready_d = (state_d == S_WLOAD);
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      k_q           <= '0;
      x_q           <= '0;
      res_data_q    <= '0;
      res_valid_q   <= 1'b0;
      wt_ready_q    <= 1'b0;
      in_ready_q    <= 1'b0;
      load_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      rst_vals_q    <= 1'b0;
      rst_overall_q <= 1'b1;
      train_q       <= '0;
      wt_upd_q      <= '0;
      value_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      k_q           <= k_d;
      x_q           <= x_d;
      res_data_q    <= res_data_d;
      res_valid_q   <= res_valid_d;
      wt_ready_q    <= wt_ready_d;
      in_ready_q    <= in_ready_d;
      load_done_q   <= load_done_d;
      busy_q        <= busy_d;
      rst_vals_q    <= rst_vals_d;
      rst_overall_q <= rst_overall_d;
      train_q       <= train_d;
      wt_upd_q      <= wt_upd_d;
      value_q       <= value_d;
    end
  end

  assign wt_ready_o          = wt_ready_q;
  assign load_done_o         = load_done_q;
  assign res_valid_o         = res_valid_q;
  assign res_data_o          = res_data_q;
  assign busy_o              = busy_q;
  assign arr_rst_vals_o      = rst_vals_q;
  assign arr_rst_overall_o   = rst_overall_q;
  assign arr_train_en_o      = train_q;
  assign arr_weight_update_o = wt_upd_q;
  assign arr_value_o         = value_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (res_valid_q && res_ready_i) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count_o = op_count_q;
`else
  assign op_count_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl
// Purpose  : Directed bench for systolic_ctrl (ROWS=2, COLS=3, DATAWIDTH=11)
//            with a behavioural PE array and a result scoreboard.
// Revision : 1.1
// ============================================================================
module tb_systolic_ctrl;
    localparam int R   = 2;
    localparam int C   = 3;
    localparam int DW  = 11;
    localparam int RW  = 2 * DW;
    localparam int NPE = R * C;

    logic              clk;
    logic              rst_n;
    logic              start_load, load_mode;
    logic              wt_valid, wt_ready;
    logic [DW-1:0]     wt_data;
    logic              load_done;
    logic              in_valid, in_ready;
    logic [C*DW-1:0]   in_data;
    logic              res_valid, res_ready;
    logic [R*RW-1:0]   res_data;
    logic              busy, rst_vals, rst_overall;
    logic [NPE-1:0]    train_en;
    logic [DW-1:0]     wt_upd;
    logic [C*DW-1:0]   arr_value;
    logic [R*RW-1:0]   arr_outp;
    logic [15:0]       op_count;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int ro_cnt   = 0;
    int ld_cnt   = 0;

    int wexp [R][C];
    int wv [NPE];
    logic [R*RW-1:0] sb [$];

    systolic_ctrl #(.ROWS(R), .COLS(C), .DATAWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_load_i(start_load), .load_mode_i(load_mode),
        .wt_valid_i(wt_valid), .wt_ready_o(wt_ready), .wt_data_i(wt_data),
        .load_done_o(load_done),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
        .busy_o(busy), .arr_rst_vals_o(rst_vals), .arr_rst_overall_o(rst_overall),
        .arr_train_en_o(train_en), .arr_weight_update_o(wt_upd),
        .arr_value_o(arr_value), .arr_outp_i(arr_outp), .op_count_o(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] pw [R][C];
    logic [RW-1:0] po [R][C];

    always @(posedge clk) begin
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (rst_overall) begin
                    pw[r][c] <= '0;
                    po[r][c] <= '0;
                end else begin
                    if (rst_vals) po[r][c] <= '0;
                    else po[r][c] <= RW'(arr_value[c*DW +: DW]) * RW'(pw[r][c])
                                     + ((c == 0) ? '0 : po[r][(c == 0) ? 0 : c - 1]);
                    if (train_en[r*C + c]) pw[r][c] <= pw[r][c] + wt_upd;
                end
            end
        end
    end

    always_comb begin
        arr_outp = '0;
        for (int r = 0; r < R; r++) arr_outp[r*RW +: RW] = po[r][C-1];
    end

    always @(negedge clk) begin
        if (rst_n && rst_overall) ro_cnt <= ro_cnt + 1;
        if (rst_n && load_done)   ld_cnt <= ld_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input bit ok,
                       input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [C*DW-1:0] pk3(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic mode, input bit with_in);
        int t;
        start_load = 1'b1;
        load_mode  = mode;
        if (with_in) begin
            in_valid = 1'b1;
            in_data  = pk3(7, 7, 7);
            #1;
            chk("simul_in_ready", in_ready === 1'b0, in_ready, 0);
        end
        step();
        start_load = 1'b0;
        in_valid   = 1'b0;
        if (with_in) begin
            chk("simul_no_cclr", rst_vals === 1'b0, rst_vals, 0);
            chk("simul_load_runs", wt_ready === 1'b1, wt_ready, 1);
        end
        if (mode == 1'b0) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) wexp[r][c] = 0;
        end
        for (int i = 0; i < NPE; i++) begin
            wt_valid = 1'b1;
            wt_data  = DW'(wv[i]);
            t = 0;
            while (!wt_ready && t < 10) begin step(); t++; end
            chk("wt_ready", wt_ready === 1'b1, wt_ready, 1);
            wexp[i / C][i % C] += wv[i];
            step();
            chk("train_onehot", train_en === (NPE'(1) << i), train_en, NPE'(1) << i);
            chk("train_word", wt_upd === DW'(wv[i]), wt_upd, DW'(wv[i]));
        end
        wt_valid = 1'b0;
        chk("load_done_pulse", load_done === 1'b1, load_done, 1);
        step();
        chk("train_clear", train_en === '0, train_en, 0);
        chk("load_idle", in_ready === 1'b1, in_ready, 1);
    endtask

    task automatic do_op(input logic [C*DW-1:0] x, input bit ld_mid);
        logic [R*RW-1:0] e;
        logic [C*DW-1:0] ev;
        int t;
        e = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                e[r*RW +: RW] = e[r*RW +: RW] + RW'(wexp[r][c]) * RW'(x[c*DW +: DW]);
        sb.push_back(e);
        in_valid = 1'b1;
        in_data  = x;
        t = 0;
        while (!in_ready && t < 20) begin step(); t++; end
        chk("in_ready", in_ready === 1'b1, in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("cclr_rst_vals", rst_vals === 1'b1, rst_vals, 1);
        chk("cclr_value", arr_value === '0, arr_value, 0);
        step();
        for (int c = 0; c < C; c++) begin
            ev = '0;
            ev[c*DW +: DW] = x[c*DW +: DW];
            chk("feed_col", arr_value === ev, arr_value, ev);
            if (ld_mid && c == 0) start_load = 1'b1;
            step();
            start_load = 1'b0;
            if (ld_mid && c == 0) chk("feed_ld_ignored", wt_ready === 1'b0, wt_ready, 0);
        end
        chk("capt_no_valid", res_valid === 1'b0, res_valid, 0);
        chk("capt_value", arr_value === '0, arr_value, 0);
        step();
        chk("res_valid_rise", res_valid === 1'b1, res_valid, 1);
    endtask

    task automatic get_res(input int hold);
        logic [R*RW-1:0] snap, e;
        int t;
        t = 0;
        while (!res_valid && t < 20) begin step(); t++; end
        chk("res_valid_wait", res_valid === 1'b1, res_valid, 1);
        snap = res_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = pk3(5, 5, 5);
            step();
            chk("bp_stable", res_data === snap, res_data, snap);
            chk("bp_in_ready", in_ready === 1'b0, in_ready, 0);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int r = 0; r < R; r++)
            chk($sformatf("y%0d", r), res_data[r*RW +: RW] === e[r*RW +: RW],
                res_data[r*RW +: RW], e[r*RW +: RW]);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        in_valid  = 1'b0;
        chk("res_dropped", res_valid === 1'b0, res_valid, 0);
        if (hold > 0) begin
            step();
            chk("bp_in_ignored", rst_vals === 1'b0, rst_vals, 0);
            chk("bp_idle", busy === 1'b0, busy, 0);
        end
    endtask

    initial begin
        int ro_base, ld_base, t;
        rst_n = 1'b0; start_load = 1'b0; load_mode = 1'b0;
        wt_valid = 1'b0; wt_data = '0; in_valid = 1'b0; in_data = '0;
        res_ready = 1'b0;

        repeat (3) step();
        chk("rst_overall", rst_overall === 1'b1, rst_overall, 1);
        chk("rst_busy", busy === 1'b0, busy, 0);
        chk("rst_in_ready", in_ready === 1'b0, in_ready, 0);
        chk("rst_res_valid", res_valid === 1'b0, res_valid, 0);
        chk("rst_op_count", op_count === 16'd0, op_count, 0);
        rst_n = 1'b1;
        step();
        chk("rel_overall", rst_overall === 1'b0, rst_overall, 0);
        chk("rel_in_ready", in_ready === 1'b1, in_ready, 1);
        chk("rel_wt_ready", wt_ready === 1'b0, wt_ready, 0);

        ro_base = ro_cnt; ld_base = ld_cnt;
        wv = '{1, 2, 3, 4, 5, 6};
        load_w(1'b0, 1'b0);
        chk("ro_once", (ro_cnt - ro_base) === 1, ro_cnt - ro_base, 1);
        chk("ld_once", (ld_cnt - ld_base) === 1, ld_cnt - ld_base, 1);
        do_op(pk3(1, 1, 1), 1'b0);
        get_res(0);

        wv = '{1, 1, 1, 1, 1, 1};
        load_w(1'b1, 1'b0);
        do_op(pk3(1, 2, 3), 1'b0);
        get_res(5);
`ifdef SYSTOLIC_CTRL_PERF_EN
        chk("op_count_two", op_count === 16'd2, op_count, 2);
`else
        chk("op_count_off", op_count === 16'd0, op_count, 0);
`endif

        ld_base = ld_cnt;
        wv = '{0, 0, 0, 0, 0, 0};
        load_w(1'b1, 1'b1);
        chk("ld_once_inc", (ld_cnt - ld_base) === 1, ld_cnt - ld_base, 1);
        do_op(pk3(1, 0, 0), 1'b1);
        get_res(0);

        in_valid = 1'b1;
        in_data  = pk3(3, 3, 3);
        t = 0;
        while (!in_ready && t < 20) begin step(); t++; end
        chk("abort_in_ready", in_ready === 1'b1, in_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("abort_busy", busy === 1'b0, busy, 0);
        chk("abort_res_valid", res_valid === 1'b0, res_valid, 0);
        chk("abort_overall", rst_overall === 1'b1, rst_overall, 1);
        rst_n = 1'b1;
        step();
        chk("abort_rel_overall", rst_overall === 1'b0, rst_overall, 0);
        chk("abort_rel_in_ready", in_ready === 1'b1, in_ready, 1);
        chk("abort_op_count", op_count === 16'd0, op_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
